// File: rtl/triggered_readout_pkg.sv
// Shared definitions for the triggered readout path: record type nibbles,
// the event buffer write-FSM state encoding and record classification helpers.
// No ports; imported by triggered_event_buffer and its testbench.
package triggered_readout_pkg;

    localparam logic [3:0] TYPE_EOE   = 4'h1;
    localparam logic [3:0] TYPE_BOD   = 4'h2;
    localparam logic [3:0] TYPE_HIT1  = 4'h3;
    localparam logic [3:0] TYPE_HIT2  = 4'h4;
    localparam logic [3:0] TYPE_DEBUG = 4'h8;
    localparam logic [3:0] TYPE_DROP  = 4'hE;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_e;

    // A word of this type closes (commits) the event it belongs to.
    function automatic logic is_event_end(input logic [3:0] rec_type);
        return (rec_type == TYPE_EOE) || (rec_type == TYPE_DEBUG);
    endfunction

    // A word of this type is the final word of an event on the output stream.
    function automatic logic is_last_word(input logic [3:0] rec_type);
        return is_event_end(rec_type) || (rec_type == TYPE_DROP);
    endfunction

endpackage

// File: rtl/event_buffer_ram.sv
// Simple dual-port RAM, one write port and one synchronous read port, written
// so it maps onto block RAM.
// Ports: clock_i; wr_en_i/wr_addr_i/wr_data_i write port; rd_en_i/rd_addr_i
// read port, rd_data_o updates one clock after rd_en_i and holds otherwise.
module event_buffer_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64
) (
    input  logic              clock_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    // Storage for buffered records, indexed by circular pointer.
    // Latency: one clock from rd_en_i to rd_data_o.
    // Backpressure: none; the caller only reads when it has room for the data.

    logic [DATA_W-1:0] mem_q [1<<ADDR_W];

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/triggered_event_buffer.sv
// Event-level buffer behind the triggered readout state machine: holds each
// event in a circular RAM and releases it to the host only once it is complete;
// events that do not fit are removed whole.
// Ports: clock/reset (sync, active-high), enable, flush, din/din_wr_en input;
// dout/dout_valid/dout_ready/dout_last output stream; fill_level,
// events_stored, dropped_events, overflow status.
// Build option: define DROP_MARKER_EN to replace each dropped event by a
// single type-E marker word carrying the drop count.
module triggered_event_buffer
    import triggered_readout_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [63:0]       din,
    input  logic              din_wr_en,
    output logic [63:0]       dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic [ADDR_W-1:0] fill_level,
    output logic [CNT_W-1:0]  events_stored,
    output logic [CNT_W-1:0]  dropped_events,
    output logic              overflow
);
    // Event store-and-forward buffer with whole-event drop on overflow.
    // Latency: first word of an event on dout 2 clocks after its committing write.
    // Backpressure: dout_ready low holds dout stable; a full buffer drops the open event.

    // rd_ptr_q counts words handed to the consumer; fetch_ptr_q runs ahead of it
    // by the words sitting in the RAM output and dout registers, so those slots
    // stay reserved until the consumer has actually taken them.
    logic [ADDR_W-1:0] wr_ptr_q, commit_ptr_q, rd_ptr_q, fetch_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_inc;
    wr_state_e         state_q;
    logic [CNT_W-1:0]  events_q, events_d, dropped_q;
    logic              overflow_q;

    logic        ram_vld_q;
    logic [63:0] dout_q;
    logic        dout_valid_q;

    logic [3:0]  din_type;
    logic        din_end, wr_ok, full;
    logic        ram_we, commit, drop_event, leave_drop;
    logic [63:0] ram_wdata, ram_rdata;
    logic        ram_re, xfer, move;

    assign din_type   = din[63:60];
    assign din_end    = is_event_end(din_type);
    assign wr_ok      = din_wr_en & enable & ~flush;
    assign wr_ptr_inc = wr_ptr_q + 1'b1;
    assign full       = (wr_ptr_inc == rd_ptr_q);

`ifdef DROP_MARKER_EN
    logic [15:0] drop_cnt16;
    assign drop_cnt16 = 16'(dropped_q);
`endif

    // Write-side decode for the current input word.
    always_comb begin
        ram_we     = 1'b0;
        ram_wdata  = din;
        commit     = 1'b0;
        drop_event = 1'b0;
        leave_drop = 1'b0;
        if (wr_ok) begin
            case (state_q)
                ACCEPT: begin
                    if (!full) begin
                        ram_we = 1'b1;
                        commit = din_end;
                    end else begin
                        drop_event = 1'b1;
                    end
                end
                DROP: begin
                    // Only a true EoE closes the dropped event; debug words do not.
                    if (din_type == TYPE_EOE) begin
                        leave_drop = 1'b1;
`ifdef DROP_MARKER_EN
                        if (!full) begin
                            ram_we    = 1'b1;
                            commit    = 1'b1;
                            ram_wdata = {TYPE_DROP, 12'd0, drop_cnt16, din[31:0]};
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Write FSM, write/commit pointers and drop bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            dropped_q    <= '0;
            overflow_q   <= 1'b0;
        end else if (flush) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
        end else begin
            if (ram_we) begin
                wr_ptr_q <= wr_ptr_inc;
            end
            if (commit) begin
                commit_ptr_q <= wr_ptr_inc;
            end
            if (drop_event) begin
                // Roll back to the last commit point: the open event vanishes.
                wr_ptr_q   <= commit_ptr_q;
                overflow_q <= 1'b1;
                if (dropped_q != {CNT_W{1'b1}}) begin
                    dropped_q <= dropped_q + 1'b1;
                end
                if (!din_end) begin
                    state_q <= DROP;
                end
            end
            if (leave_drop) begin
                state_q <= ACCEPT;
            end
        end
    end

    // Read side: RAM output register feeds dout; a new fetch is issued whenever
    // the RAM output slot is empty or is being moved on this cycle.
    assign xfer   = dout_valid_q & dout_ready;
    assign move   = ram_vld_q & (~dout_valid_q | dout_ready);
    assign ram_re = (fetch_ptr_q != commit_ptr_q) & (~ram_vld_q | move);

    always_comb begin
        events_d = events_q;
        case ({commit, xfer & dout_last})
            2'b10:   events_d = events_q + 1'b1;
            2'b01:   events_d = events_q - 1'b1;
            default: events_d = events_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            ram_vld_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            events_q     <= '0;
        end else if (flush) begin
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            ram_vld_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            events_q     <= '0;
        end else begin
            if (ram_re) begin
                fetch_ptr_q <= fetch_ptr_q + 1'b1;
            end
            if (xfer) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            ram_vld_q    <= ram_re | (ram_vld_q & ~move);
            dout_valid_q <= move | (dout_valid_q & ~dout_ready);
            if (move) begin
                dout_q <= ram_rdata;
            end
            events_q <= events_d;
        end
    end

    event_buffer_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (64)
    ) u_ram (
        .clock_i   (clock),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (ram_wdata),
        .rd_en_i   (ram_re),
        .rd_addr_i (fetch_ptr_q),
        .rd_data_o (ram_rdata)
    );

    assign dout           = dout_q;
    assign dout_valid     = dout_valid_q;
    assign dout_last      = dout_valid_q & is_last_word(dout_q[63:60]);
    assign fill_level     = wr_ptr_q - rd_ptr_q;
    assign events_stored  = events_q;
    assign dropped_events = dropped_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_triggered_event_buffer.sv
// Testbench for triggered_event_buffer (ADDR_W=4: 15-word capacity).
module tb_triggered_event_buffer;

    localparam int AW  = 4;
    localparam int CAP = (1 << AW) - 1;
    localparam int CW  = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [63:0]   din = '0;
    logic          din_wr_en = 1'b0;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          dout_last;
    logic [AW-1:0] fill_level;
    logic [CW-1:0] events_stored;
    logic [CW-1:0] dropped_events;
    logic          overflow;

    always #5 clock = ~clock;

    triggered_event_buffer #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .din            (din),
        .din_wr_en      (din_wr_en),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_last      (dout_last),
        .fill_level     (fill_level),
        .events_stored  (events_stored),
        .dropped_events (dropped_events),
        .overflow       (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: the buffer as a count of committed-but-unread words plus
    // the list of words of the event currently being assembled.
    logic [64:0] exp_q[$];     // {last, word} in the order the host must see them
    logic [63:0] m_open[$];
    int          m_cw = 0;
    int          m_events = 0;
    int          m_dropped = 0;
    bit          m_drop = 0;
    bit          m_ovf = 0;
    int          rdy_pct = 100;

    function automatic bit closes_event(input logic [3:0] t);
        return (t == 4'h1) || (t == 4'h8);
    endfunction

    function automatic logic [63:0] mkw(input logic [3:0] t);
        return {t, 28'($urandom()), $urandom()};
    endfunction

    task automatic commit_open();
        for (int i = 0; i < m_open.size(); i++)
            exp_q.push_back({(i == m_open.size() - 1), m_open[i]});
        m_cw += m_open.size();
        m_events++;
        m_open.delete();
    endtask

    // Predict the effect of the coming clock edge.
    task automatic model_step(input bit wr, input logic [63:0] d, input bit fl, input bit xfer);
        bit full;
        bit xfer_last;
        logic [3:0] t;
        if (fl) begin
            m_open.delete();
            exp_q.delete();
            m_cw = 0;
            m_events = 0;
            m_drop = 0;
            return;
        end
        full = (m_cw + m_open.size() == CAP);
        xfer_last = xfer && (exp_q.size() > 0) && exp_q[0][64];
        t = d[63:60];
        if (wr) begin
            if (!m_drop) begin
                if (!full) begin
                    m_open.push_back(d);
                    if (closes_event(t)) commit_open();
                end else begin
                    m_open.delete();
                    if (m_dropped < 65535) m_dropped++;
                    m_ovf = 1;
                    if (!closes_event(t)) m_drop = 1;
                end
            end else if (t == 4'h1) begin
                m_drop = 0;
`ifdef DROP_MARKER_EN
                if (!full) begin
                    m_open.push_back({4'hE, 12'd0, 16'(m_dropped), d[31:0]});
                    commit_open();
                end
`endif
            end
        end
        if (xfer) begin
            if (m_cw > 0) m_cw--;
            if (xfer_last) m_events--;
        end
    endtask

    task automatic check_status();
        chk("fill_level", 64'(fill_level), 64'((m_cw + m_open.size()) % (1 << AW)));
        chk("events_stored", 64'(events_stored), 64'(m_events));
        chk("dropped_events", 64'(dropped_events), 64'(m_dropped));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // One clock: check post-edge status, drive next inputs, predict next edge.
    task automatic step(input bit wr, input logic [63:0] d, input bit fl = 1'b0, input bit en = 1'b1);
        @(posedge clock);
        #1;
        check_status();
        din_wr_en  = wr;
        din        = d;
        flush      = fl;
        enable     = en;
        dout_ready = fl ? 1'b0 : ($urandom_range(99) < rdy_pct);
        model_step(wr && en, d, fl, dout_valid && dout_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0);
    endtask

    task automatic send_event(input int hits);
        step(1'b1, mkw(4'h2));
        for (int i = 0; i < hits; i++) step(1'b1, mkw((i % 2 == 0) ? 4'h3 : 4'h4));
        step(1'b1, mkw(4'h1));
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold stability.
    bit          prev_hold = 0;
    logic [63:0] prev_dout;
    logic        prev_last;

    always @(negedge clock) begin
        logic [64:0] e;
        if (!reset) begin
            if (prev_hold) begin
                chk("hold_valid", 64'(dout_valid), 64'd1);
                chk("hold_dout", dout, prev_dout);
                chk("hold_last", 64'(dout_last), 64'(prev_last));
            end
            prev_hold = dout_valid && !dout_ready && !flush;
            prev_dout = dout;
            prev_last = dout_last;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h, expected no word", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", dout, e[63:0]);
                    chk("dout_last", 64'(dout_last), 64'(e[64]));
                end
            end
        end
    end

    initial begin
        int saved_drop;
        int r;
        int tr;
        logic [3:0] t;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        enable = 1'b1;
        chk("reset_dout_valid", 64'(dout_valid), 64'd0);
        chk("reset_dout_last", 64'(dout_last), 64'd0);
        chk("reset_dout", dout, 64'd0);
        chk("reset_fill", 64'(fill_level), 64'd0);
        chk("reset_events", 64'(events_stored), 64'd0);
        chk("reset_dropped", 64'(dropped_events), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);

        // 1: one 4-word event with ready high; first word two clocks after EoE.
        rdy_pct = 100;
        send_event(2);
        step(1'b0, 64'd0);
        chk("latency_e0", 64'(dout_valid), 64'd0);
        step(1'b0, 64'd0);
        chk("latency_e1", 64'(dout_valid), 64'd0);
        step(1'b0, 64'd0);
        chk("latency_e2", 64'(dout_valid), 64'd1);
        idle(6);

        // 2: three events held back, then released back-to-back.
        rdy_pct = 0;
        for (int e = 0; e < 3; e++) send_event(2);
        idle(4);
        chk("held_events", 64'(events_stored), 64'd3);
        chk("held_fill", 64'(fill_level), 64'd12);
        chk("held_valid", 64'(dout_valid), 64'd1);
        rdy_pct = 100;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 64'd0);
            chk("throughput", 64'(dout_valid), 64'd1);
        end
        idle(4);

        // 3: 20-word event exceeds capacity; the following event passes.
        send_event(18);
        idle(4);
        chk("long_dropped", 64'(dropped_events), 64'd1);
        chk("long_overflow", 64'(overflow), 64'd1);
        chk("long_fill", 64'(fill_level), 64'd0);
        send_event(2);
        idle(8);

        // 4: 14 committed words, a 3-word event racing the reads (drop, then pass).
        for (int pass = 0; pass < 2; pass++) begin
            rdy_pct = 0;
            for (int e = 0; e < 3; e++) send_event(2);
            send_event(0);
            idle(3);
            chk("near_full_fill", 64'(fill_level), 64'd14);
            step(1'b1, mkw(4'h2));
            if (pass == 1) begin
                rdy_pct = 100;
                idle(2);
            end
            step(1'b1, mkw(4'h3));
            step(1'b1, mkw(4'h1));
            rdy_pct = 100;
            idle(25);
        end

        // 5: lone debug word; debug words during DROP are discarded.
        step(1'b1, mkw(4'h8));
        idle(4);
        send_event(15);
        idle(2);
        step(1'b1, mkw(4'h2));
        for (int i = 0; i < 16; i++) step(1'b1, mkw(4'h3));
        step(1'b1, mkw(4'h8));
        step(1'b1, mkw(4'h8));
        step(1'b1, mkw(4'h4));
        step(1'b1, mkw(4'h1));
        idle(6);
        send_event(1);
        idle(8);

        // 6: flush with output valid and an open event; flush-cycle write ignored.
        rdy_pct = 0;
        send_event(2);
        idle(3);
        step(1'b1, mkw(4'h2));
        step(1'b1, mkw(4'h3));
        saved_drop = m_dropped;
        step(1'b1, mkw(4'h3), 1'b1);
        step(1'b0, 64'd0);
        chk("flush_valid", 64'(dout_valid), 64'd0);
        chk("flush_fill", 64'(fill_level), 64'd0);
        chk("flush_events", 64'(events_stored), 64'd0);
        chk("flush_dropped", 64'(dropped_events), 64'(saved_drop));
        rdy_pct = 100;
        send_event(2);
        idle(8);

        // Random traffic.
        for (int c = 0; c < 2500; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(0, 100);
            r = $urandom_range(99);
            tr = $urandom_range(99);
            t = (tr < 12) ? 4'h1 : (tr < 15) ? 4'h8 : (tr < 35) ? 4'h2 :
                (tr < 60) ? 4'h3 : (tr < 85) ? 4'h4 : 4'h5;
            if (r < 55)      step(1'b1, mkw(t));
            else if (r < 60) step(1'b1, mkw(t), 1'b0, 1'b0);
            else if (r < 61) step(1'b1, mkw(t), 1'b1);
            else             step(1'b0, 64'd0);
        end

        // Drain, bounded.
        rdy_pct = 100;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) step(1'b0, 64'd0);
        idle(4);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
